// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT    = 2'd0,
        WAIT_LOCK = 2'd1,
        SEQ       = 2'd2,
        RUN       = 2'd3
    } rseq_state_t;

    localparam int LOSS_CNT_W = 8;

    // Largest of three timing parameters; sizes the shared counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Generic multi-flop synchroniser for a single asynchronous bit.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the flop chain; cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Holds N_CH reset outputs until the PLL lock is stable, then releases them
// one at a time in index order. Lock loss or a software request re-asserts all.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ASSERT    | all outputs held, minimum assertion time running
// WAIT_LOCK | all outputs held, counting consecutive synced-locked cycles
// SEQ       | releasing channels one by one, STEP_DLY cycles apart
// RUN       | all channels released, rst_done high
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int MIN_ASSERT  = 8,
    parameter int STEP_DLY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked_in,
    input  logic                  sw_rst_req,
    output logic [N_CH-1:0]       rst_out,
    output logic                  rst_done,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_MAX = max3(MIN_ASSERT, LOCK_FILTER, STEP_DLY);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(N_CH) + 1;

    localparam logic [CNT_W-1:0] MA_LAST   = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CH - 1);

    rseq_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             armed;
    logic             locked_s;
    logic             active;
    logic             lock_fault;
    logic             fault;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked_in),
        .q   (locked_s)
    );

    // Lock loss only matters once release has started; a software request
    // restarts the sequence from any state except ASSERT, where it just
    // extends the hold time.
    assign active     = (state == SEQ) || (state == RUN);
    assign lock_fault = active && !locked_s;
    assign fault      = lock_fault || (sw_rst_req && (state != ASSERT));

    // Sequencer FSM with shared timer, channel index, outputs and lock-loss counter.
    // The first edge after reset release only arms the FSM, so the hold time
    // is measured from a clean edge rather than from the reset deassertion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ASSERT;
            cnt           <= '0;
            idx           <= '0;
            armed         <= 1'b0;
            rst_out       <= '1;
            rst_done      <= 1'b0;
            lock_loss_cnt <= '0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else if (fault) begin
            state    <= ASSERT;
            cnt      <= '0;
            idx      <= '0;
            rst_out  <= '1;
            rst_done <= 1'b0;
            if (lock_fault && (lock_loss_cnt != '1)) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
        end else begin
            case (state)
                ASSERT: begin
                    rst_out  <= '1;
                    rst_done <= 1'b0;
                    idx      <= '0;
                    if (sw_rst_req) begin
                        cnt <= '0;
                    end else if (cnt == MA_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (!locked_s) begin
                        cnt <= '0;
                    end else if (cnt == LF_LAST) begin
                        state <= SEQ;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEQ: begin
                    if (cnt == STEP_LAST) begin
                        cnt <= '0;
                        for (int k = 0; k < N_CH; k++) begin
                            if (idx == IDX_W'(k)) begin
                                rst_out[k] <= 1'b0;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            state    <= RUN;
                            rst_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    rst_out  <= '0;
                    rst_done <= 1'b1;
                end
                default: begin
                    state <= ASSERT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (default parameters plus an N_CH=1 copy).
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       locked_in = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] rst_out;
    logic       rst_done;
    logic [7:0] lock_loss_cnt;
    logic [0:0] rst_out1;
    logic       rst_done1;
    logic [7:0] lock_loss_cnt1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    reset_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .locked_in     (locked_in),
        .sw_rst_req    (sw_rst_req),
        .rst_out       (rst_out),
        .rst_done      (rst_done),
        .lock_loss_cnt (lock_loss_cnt)
    );

    reset_sequencer #(.N_CH(1)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .locked_in     (locked_in),
        .sw_rst_req    (sw_rst_req),
        .rst_out       (rst_out1),
        .rst_done      (rst_done1),
        .lock_loss_cnt (lock_loss_cnt1)
    );

    typedef struct {
        int         cyc;
        logic [3:0] ro;
        logic       done;
        logic [7:0] llc;
        bit         chk1;
        logic       ro1;
        logic       done1;
    } exp_t;

    exp_t exp_q[$];
    exp_t pu_tab[10];
    int   base = 0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", name, act, expv, cyc - base);
    endtask

    // Edge numbered 0 is the next posedge after this call (call just after a negedge).
    task automatic set_origin();
        base = cyc + 1;
    endtask

    task automatic expect_at(input int c, input logic [3:0] ro, input logic done, input logic [7:0] llc);
        exp_t e;
        e = '{c, ro, done, llc, 1'b0, 1'b0, 1'b0};
        exp_q.push_back(e);
    endtask

    // Advance n cycles, scoring every queued expectation whose cycle has been reached.
    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc - base) begin
                e = exp_q.pop_front();
                check($sformatf("rst_out@%0d", e.cyc), 32'(rst_out), 32'(e.ro));
                check($sformatf("rst_done@%0d", e.cyc), 32'(rst_done), 32'(e.done));
                check($sformatf("lock_loss_cnt@%0d", e.cyc), 32'(lock_loss_cnt), 32'(e.llc));
                if (e.chk1) begin
                    check($sformatf("n1_rst_out@%0d", e.cyc), 32'(rst_out1), 32'(e.ro1));
                    check($sformatf("n1_rst_done@%0d", e.cyc), 32'(rst_done1), 32'(e.done1));
                end
            end
        end
    endtask

    task automatic push_powerup();
        for (int i = 0; i < 10; i++) exp_q.push_back(pu_tab[i]);
    endtask

    initial begin
        pu_tab[0] = '{0,  4'hF, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
        pu_tab[1] = '{27, 4'hF, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
        pu_tab[2] = '{28, 4'hE, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
        pu_tab[3] = '{31, 4'hE, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        pu_tab[4] = '{32, 4'hC, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        pu_tab[5] = '{35, 4'hC, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        pu_tab[6] = '{36, 4'h8, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        pu_tab[7] = '{39, 4'h8, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        pu_tab[8] = '{40, 4'h0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1};
        pu_tab[9] = '{50, 4'h0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};

        // Power-up with lock held high throughout.
        #2 rst = 1'b1;
        step(3);
        check("reset_rst_out", 32'(rst_out), 32'hF);
        check("reset_rst_done", 32'(rst_done), 32'h0);
        check("reset_llc", 32'(lock_loss_cnt), 32'h0);
        rst = 1'b0;
        set_origin();
        push_powerup();
        step(52);

        // Lock glitch during WAIT_LOCK restarts the filter.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        set_origin();
        expect_at(28, 4'hF, 1'b0, 8'd0);
        expect_at(36, 4'hF, 1'b0, 8'd0);
        expect_at(37, 4'hE, 1'b0, 8'd0);
        expect_at(41, 4'hC, 1'b0, 8'd0);
        expect_at(45, 4'h8, 1'b0, 8'd0);
        expect_at(48, 4'h8, 1'b0, 8'd0);
        expect_at(49, 4'h0, 1'b1, 8'd0);
        step(15);
        locked_in = 1'b0;
        step(1);
        locked_in = 1'b1;
        step(40);

        // Lock loss in RUN, then recovery with the same spacing.
        locked_in = 1'b0;
        set_origin();
        expect_at(1, 4'h0, 1'b1, 8'd0);
        expect_at(2, 4'hF, 1'b0, 8'd1);
        step(3);
        locked_in = 1'b1;
        expect_at(29, 4'hF, 1'b0, 8'd1);
        expect_at(30, 4'hE, 1'b0, 8'd1);
        expect_at(34, 4'hC, 1'b0, 8'd1);
        expect_at(38, 4'h8, 1'b0, 8'd1);
        expect_at(41, 4'h8, 1'b0, 8'd1);
        expect_at(42, 4'h0, 1'b1, 8'd1);
        step(45);

        // Software request in RUN, again in SEQ, and once in ASSERT.
        sw_rst_req = 1'b1;
        set_origin();
        expect_at(0, 4'hF, 1'b0, 8'd1);
        step(1);
        sw_rst_req = 1'b0;
        expect_at(27, 4'hF, 1'b0, 8'd1);
        expect_at(28, 4'hE, 1'b0, 8'd1);
        expect_at(32, 4'hC, 1'b0, 8'd1);
        expect_at(33, 4'hC, 1'b0, 8'd1);
        expect_at(34, 4'hF, 1'b0, 8'd1);
        step(33);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(3);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        expect_at(65, 4'hF, 1'b0, 8'd1);
        expect_at(66, 4'hE, 1'b0, 8'd1);
        expect_at(70, 4'hC, 1'b0, 8'd1);
        expect_at(74, 4'h8, 1'b0, 8'd1);
        expect_at(77, 4'h8, 1'b0, 8'd1);
        expect_at(78, 4'h0, 1'b1, 8'd1);
        step(45);

        // Asynchronous reset in the middle of SEQ.
        sw_rst_req = 1'b1;
        set_origin();
        step(1);
        sw_rst_req = 1'b0;
        step(30);
        check("pre_rst_rst_out", 32'(rst_out), 32'hE);
        rst = 1'b1;
        #1;
        check("async_rst_out", 32'(rst_out), 32'hF);
        check("async_rst_done", 32'(rst_done), 32'h0);
        check("async_rst_llc", 32'(lock_loss_cnt), 32'h0);
        step(2);
        rst = 1'b0;
        set_origin();
        push_powerup();
        step(52);

        // Many lock-loss events: counter saturates.
        for (int i = 1; i <= 300; i++) begin
            locked_in = 1'b0;
            step(4);
            locked_in = 1'b1;
            step(36);
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
                check($sformatf("llc_after_%0d", i), 32'(lock_loss_cnt), (i < 255) ? 32'(i) : 32'd255);
        end
        step(10);
        check("final_rst_done", 32'(rst_done), 32'h1);
        check("final_rst_out", 32'(rst_out), 32'h0);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
